// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;
  localparam int TIMEOUT_DEF = 15;
  localparam int STARVE_DEF  = 4;
  function automatic logic is_word(input logic [1:0] s);
    return s == SZ_WORD || s == 2'b00;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane logic for data accesses (enables, store replication, load extraction, alignment)
// Ports: size/off select the access; wdata/rdata in; be, wrep, rext, mis out.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext,
  output logic        mis
);
  always_comb begin
    be   = is_word(size) ? 4'b1111 : size == SZ_HALF ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
    wrep = is_word(size) ? wdata : size == SZ_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rext = is_word(size) ? rdata : size == SZ_HALF ? {16'h0, off[1] ? rdata[31:16] : rdata[15:0]}
                                 : {24'h0, rdata[{off, 3'b000} +: 8]};
    mis  = is_word(size) ? |off : size == SZ_HALF ? off[0] : 1'b0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch port and a data port
// Ports: clk, reset (sync, active-low); if_* fetch request/result; d_* data request/result;
//        mem_req/addr/we/be/wdata registered memory request; mem_ready/mem_rdata memory response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] starve_q, starve_d;
  logic mis_q, mis_d;
  logic [1:0] sz_q, sz_d, off_q, off_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic if_valid_q, if_valid_d, if_err_q, if_err_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic [1:0] lane_size, lane_off;
  logic [3:0] lane_be;
  logic [31:0] lane_wrep, lane_rext, res;
  logic lane_mis, gnt_d, done, tout, err;
  // In IDLE the lane logic decodes the incoming data request; while busy it decodes the captured one.
  assign lane_size = state_q == IDLE ? d_size : sz_q;
  assign lane_off  = state_q == IDLE ? d_addr[1:0] : off_q;
  mem_lane_align u_lane (
    .size(lane_size), .off(lane_off), .wdata(d_wdata), .rdata(mem_rdata),
    .be(lane_be), .wrep(lane_wrep), .rext(lane_rext), .mis(lane_mis)
  );
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    mis_d       = mis_q;
    sz_d        = sz_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;
    // Data wins unless the fetch side has been passed over STARVE_LIMIT times in a row.
    gnt_d = d_req && !(if_req && starve_q == SW'(STARVE_LIMIT));
    tout  = !mis_q && !mem_ready && wait_q == WW'(TIMEOUT);
    done  = mis_q || mem_ready || tout;
    err   = mis_q || tout;
    res   = err ? 32'h0 : state_q == IF_BUSY ? mem_rdata : lane_rext;
    if (state_q == IDLE) begin
      if (gnt_d) begin
        state_d     = D_BUSY;
        wait_d      = '0;
        mis_d       = lane_mis;
        sz_d        = d_size;
        off_d       = d_addr[1:0];
        mem_req_d   = !lane_mis;
        mem_addr_d  = {d_addr[31:2], 2'b00};
        mem_we_d    = d_we;
        mem_be_d    = lane_be;
        mem_wdata_d = lane_wrep;
        if (if_req && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
      end else if (if_req) begin
        state_d     = IF_BUSY;
        wait_d      = '0;
        starve_d    = '0;
        mis_d       = |if_addr[1:0];
        mem_req_d   = ~|if_addr[1:0];
        mem_addr_d  = {if_addr[31:2], 2'b00};
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b1111;
        mem_wdata_d = '0;
      end
    end else if (done) begin
      state_d    = IDLE;
      mem_req_d  = 1'b0;
      if_valid_d = state_q == IF_BUSY;
      if_err_d   = state_q == IF_BUSY && err;
      if_rdata_d = state_q == IF_BUSY ? res : if_rdata_q;
      d_valid_d  = state_q == D_BUSY;
      d_err_d    = state_q == D_BUSY && err;
      d_rdata_d  = state_q == D_BUSY ? res : d_rdata_q;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      mis_q       <= 1'b0;
      sz_q        <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      mis_q       <= mis_d;
      sz_q        <= sz_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
    end
  end
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
endmodule
